// File: rtl/vga_timing_gen_param.sv
// Parameterised VGA timing generator: pixel/line counters, scaled fetch coordinates,
// and a two-stage output pipeline that keeps colour, syncs and enable aligned.
module vga_timing_gen_param #(
    parameter int unsigned H_ACTIVE   = 800,
    parameter int unsigned H_FP       = 40,
    parameter int unsigned H_SYNC     = 128,
    parameter int unsigned H_BP       = 88,
    parameter int unsigned V_ACTIVE   = 600,
    parameter int unsigned V_FP       = 1,
    parameter int unsigned V_SYNC     = 4,
    parameter int unsigned V_BP       = 23,
    parameter bit          HSYNC_POL  = 1'b1,
    parameter bit          VSYNC_POL  = 1'b1,
    parameter int unsigned COLOR_BITS = 2,
    parameter int unsigned SCALE_X    = 4,
    parameter int unsigned SCALE_Y    = 4,
    localparam int unsigned XW = (H_ACTIVE / SCALE_X > 1) ? $clog2(H_ACTIVE / SCALE_X) : 1,
    localparam int unsigned YW = (V_ACTIVE / SCALE_Y > 1) ? $clog2(V_ACTIVE / SCALE_Y) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [COLOR_BITS-1:0] i_red,
    input  logic [COLOR_BITS-1:0] i_green,
    input  logic [COLOR_BITS-1:0] i_blue,
    output logic                  o_fetch,
    output logic [XW-1:0]         o_x,
    output logic [YW-1:0]         o_y,
    output logic [COLOR_BITS-1:0] o_red,
    output logic [COLOR_BITS-1:0] o_green,
    output logic [COLOR_BITS-1:0] o_blue,
    output logic                  o_hsync,
    output logic                  o_vsync,
    output logic                  o_de,
    output logic                  o_frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HCW     = $clog2(H_TOTAL + 1);
    localparam int unsigned VCW     = $clog2(V_TOTAL + 1);
    localparam int unsigned SXW     = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
    localparam int unsigned SYW     = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;

    // Async assert, synchronous release of the internal reset
    logic [1:0] rst_sync;
    logic       rst_s;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_s = rst_sync[1];

    logic [HCW-1:0] hc;
    logic [VCW-1:0] vc;
    logic [SXW-1:0] xsub;
    logic [SYW-1:0] ysub;
    logic [XW-1:0]  xq;
    logic [YW-1:0]  yq;
    logic           h_wrap;
    logic           v_wrap;
    logic           active;
    logic           hs_on;
    logic           vs_on;
    logic           origin;

    assign h_wrap = (hc == HCW'(H_TOTAL - 1));
    assign v_wrap = (vc == VCW'(V_TOTAL - 1));
    assign active = (hc < HCW'(H_ACTIVE)) && (vc < VCW'(V_ACTIVE));
    assign hs_on  = (hc >= HCW'(H_ACTIVE + H_FP)) && (hc < HCW'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_on  = (vc >= VCW'(V_ACTIVE + V_FP)) && (vc < VCW'(V_ACTIVE + V_FP + V_SYNC));
    assign origin = (hc == '0) && (vc == '0);

    // Raster counters; xq/yq track hc/SCALE_X and vc/SCALE_Y without division
    always_ff @(posedge i_clk or negedge rst_s) begin
        if (!rst_s) begin
            hc   <= '0;
            vc   <= '0;
            xsub <= '0;
            ysub <= '0;
            xq   <= '0;
            yq   <= '0;
        end else if (h_wrap) begin
            hc   <= '0;
            xsub <= '0;
            xq   <= '0;
            if (v_wrap) begin
                vc   <= '0;
                ysub <= '0;
                yq   <= '0;
            end else begin
                vc <= vc + VCW'(1);
                if (vc < VCW'(V_ACTIVE - 1)) begin
                    if (ysub == SYW'(SCALE_Y - 1)) begin
                        ysub <= '0;
                        yq   <= yq + YW'(1);
                    end else begin
                        ysub <= ysub + SYW'(1);
                    end
                end
            end
        end else begin
            hc <= hc + HCW'(1);
            if (hc < HCW'(H_ACTIVE - 1)) begin
                if (xsub == SXW'(SCALE_X - 1)) begin
                    xsub <= '0;
                    xq   <= xq + XW'(1);
                end else begin
                    xsub <= xsub + SXW'(1);
                end
            end
        end
    end

    // Stage 1: fetch request and delayed timing terms
    logic de1;
    logic hs1;
    logic vs1;
    logic fs1;

    always_ff @(posedge i_clk or negedge rst_s) begin
        if (!rst_s) begin
            o_fetch <= 1'b0;
            o_x     <= '0;
            o_y     <= '0;
            de1     <= 1'b0;
            hs1     <= ~HSYNC_POL;
            vs1     <= ~VSYNC_POL;
            fs1     <= 1'b0;
        end else begin
            o_fetch <= active;
            de1     <= active;
            if (active) begin
                o_x <= xq;
                o_y <= yq;
            end
            hs1 <= hs_on ? HSYNC_POL : ~HSYNC_POL;
            vs1 <= vs_on ? VSYNC_POL : ~VSYNC_POL;
            fs1 <= origin;
        end
    end

    // Stage 2: pins; colour is the pixel fetched during stage 1, blanked outside active
    always_ff @(posedge i_clk or negedge rst_s) begin
        if (!rst_s) begin
            o_red         <= '0;
            o_green       <= '0;
            o_blue        <= '0;
            o_hsync       <= ~HSYNC_POL;
            o_vsync       <= ~VSYNC_POL;
            o_de          <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            o_red         <= de1 ? i_red   : '0;
            o_green       <= de1 ? i_green : '0;
            o_blue        <= de1 ? i_blue  : '0;
            o_hsync       <= hs1;
            o_vsync       <= vs1;
            o_de          <= de1;
            o_frame_start <= fs1;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen_param.sv
// Self-checking bench for vga_timing_gen_param on a small raster; expectations come from
// a pixel-index model of the frame (position = cycles since counter start, mod frame size).
module tb_vga_timing_gen_param;

    localparam int unsigned HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int unsigned VA = 8, VF = 1, VS = 2, VB = 1;
    localparam int unsigned CB = 2, SX = 4, SY = 2;
    localparam bit HP = 1'b0, VP = 1'b1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    logic          clk = 1'b0;
    logic          i_rst_n;
    logic [CB-1:0] i_red, i_green, i_blue;
    logic          o_fetch;
    logic [1:0]    o_x;
    logic [1:0]    o_y;
    logic [CB-1:0] o_red, o_green, o_blue;
    logic          o_hsync, o_vsync, o_de, o_frame_start;

    always #5 clk = ~clk;

    vga_timing_gen_param #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(HP), .VSYNC_POL(VP),
        .COLOR_BITS(CB), .SCALE_X(SX), .SCALE_Y(SY)
    ) dut (
        .i_clk(clk), .i_rst_n(i_rst_n),
        .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
        .o_fetch(o_fetch), .o_x(o_x), .o_y(o_y),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
        .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de),
        .o_frame_start(o_frame_start)
    );

    int checks = 0;
    int errors = 0;
    int s;        // clock edges since reset release
    int mx, my;   // model of held fetch coordinates
    bit cap_mode; // colour inputs currently presented were derived from o_x

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, s);
        end
    endtask

    // Two synchronizer edges, then stage 1 shows pixel s-3 and stage 2 pixel s-4
    task automatic check_all();
        int q, h, v;
        bit a;
        logic [31:0] e_fetch, e_de, e_hs, e_vs, e_fs, e_r, e_g, e_b;
        if (s >= 3) begin
            q = (s - 3) % FR; h = q % HT; v = q / HT;
            a = (h < HA) && (v < VA);
            if (a) begin
                mx = h / SX;
                my = v / SY;
            end
            e_fetch = 32'(a);
        end else begin
            mx = 0; my = 0; e_fetch = 0;
        end
        chk("fetch", 32'(o_fetch), e_fetch);
        chk("x", 32'(o_x), mx);
        chk("y", 32'(o_y), my);
        if (s >= 4) begin
            q = (s - 4) % FR; h = q % HT; v = q / HT;
            a = (h < HA) && (v < VA);
            e_de = 32'(a);
            e_hs = (h >= HA + HF && h < HA + HF + HS) ? 32'(HP) : 32'(!HP);
            e_vs = (v >= VA + VF && v < VA + VF + VS) ? 32'(VP) : 32'(!VP);
            e_fs = 32'(q == 0);
            e_r  = a ? (cap_mode ? 32'((h / SX) % 4) : 32'(i_red)) : 0;
            e_g  = a ? 32'(i_green) : 0;
            e_b  = a ? 32'(i_blue) : 0;
        end else begin
            e_de = 0; e_hs = 32'(!HP); e_vs = 32'(!VP); e_fs = 0;
            e_r = 0; e_g = 0; e_b = 0;
        end
        chk("de", 32'(o_de), e_de);
        chk("hsync", 32'(o_hsync), e_hs);
        chk("vsync", 32'(o_vsync), e_vs);
        chk("frame_start", 32'(o_frame_start), e_fs);
        chk("red", 32'(o_red), e_r);
        chk("green", 32'(o_green), e_g);
        chk("blue", 32'(o_blue), e_b);
    endtask

    task automatic drive(input bit m);
        if (m) i_red = o_x;
        else   i_red = CB'($urandom);
        i_green  = CB'($urandom);
        i_blue   = CB'($urandom);
        cap_mode = m;
    endtask

    task automatic run(input int n, input bit m);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            s++;
            @(negedge clk);
            check_all();
            drive(m);
        end
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_red = '0; i_green = '0; i_blue = '0;
        s = 0; mx = 0; my = 0; cap_mode = 1'b0;

        // Reset state held across clock edges
        repeat (3) begin
            @(negedge clk);
            check_all();
        end
        drive(1'b0);
        i_rst_n = 1'b1;

        run(2 * FR + 10, 1'b0);   // random colour, two full frames
        run(FR, 1'b1);            // colour derived from o_x: alignment check
        run(FR / 2 + 37, 1'b0);   // stop mid-frame

        // Mid-frame reset: outputs must drop to reset values without a clock edge
        #2 i_rst_n = 1'b0;
        #1 s = 0;
        check_all();
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_all();
        end
        drive(1'b0);
        i_rst_n = 1'b1;

        run(2 * FR + 10, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
